dac_tx_start_sequencer: RTL and testbench
=========================================

// Module: dac_tx_start_sequencer
// PURPOSE
// - Sequences start/stop of the JESD204 DAC transmit datapath: arm, optional external sync, start delay, run.
// - Drives per-channel DMA dac_valid; tells the datapath to zero-fill or halt on DMA underflow.
// - Sits between the up/regmap control and the DAC core's DMA/JESD handshake, all in the dac_clk domain.
// PARAMETERS
// - NUM_CHANNELS       4   DMA channels sequenced (2 or 4)
// - START_DELAY_WIDTH  16  width of start delay counter, in dac_clk cycles
// - UNF_CNT_WIDTH      16  width of underflow event counter (optional feature only)
// PORTS
// - dac_clk          in   1                  datapath clock (tx_clk, line-rate/40)
// - dac_rst          in   1                  synchronous, active-high reset
// - ctrl_arm         in   1                  pulse: arm sequencer
// - ctrl_stop        in   1                  pulse: stop, return to IDLE
// - ctrl_ext_sync_en in   1                  1 = wait for ext_sync rising edge after arm
// - ctrl_unf_halt    in   1                  1 = halt on underflow; 0 = zero-fill and continue
// - ctrl_unf_clr     in   1                  pulse: clear underflow status
// - start_delay      in   START_DELAY_WIDTH  cycles from trigger to RUN
// - chan_enable      in   NUM_CHANNELS       channel enables, latched on accepted arm
// - ext_sync         in   1                  external trigger, already synchronous to dac_clk
// - tx_ready         in   1                  JESD link accepting data
// - dac_dunf         in   1                  DMA underflow
// - dac_valid        out  NUM_CHANNELS       per-channel DMA read strobe
// - dac_data_zero    out  1                  1 = datapath outputs zeros this cycle
// - tx_valid         out  1                  datapath drives JESD link
// - seq_state        out  3                  current state encoding
// - unf_sticky       out  1                  underflow seen since last clear
// - unf_count        out  UNF_CNT_WIDTH      underflow cycles (only with macro)
// BEHAVIOUR
// - States: IDLE=0, ARMED=1, DELAY=2, RUN=3, HALT=4. All state and outputs are registered, except dac_valid.
// - Reset values: state IDLE; all outputs 0; latched enables 0; delay counter 0.
// - IDLE: ctrl_arm with chan_enable!=0 -> latch chan_enable, go ARMED. Arm with chan_enable==0 is ignored.
// - ARMED: ext_sync_en=0 -> DELAY next cycle. ext_sync_en=1 -> DELAY on ext_sync 0->1 edge only.
//   A level already high at arm does not trigger.
// - DELAY: counter loads start_delay on entry and decrements. At count==0 and tx_ready=1 -> RUN.
//   start_delay=0 gives exactly one DELAY cycle. count==0 with tx_ready=0 holds in DELAY.
// - RUN: tx_valid=1. dac_valid = latched_enable & {NUM_CHANNELS{tx_ready}} (combinational gate on tx_ready).
// - Underflow in RUN, unf_halt=0: dac_data_zero=1 on the cycle after each dac_dunf cycle; state stays RUN.
// - Underflow in RUN, unf_halt=1: -> HALT next cycle.
// - HALT: tx_valid=1 (link fed zeros), dac_data_zero=1, dac_valid=0. ctrl_arm -> ARMED, reusing latched enables.
// - ctrl_stop from any state -> IDLE next cycle; tx_valid, dac_valid, dac_data_zero drop with it.
// - ctrl_stop wins over ctrl_arm in the same cycle.
// - ctrl_arm in ARMED/DELAY/RUN is ignored.
// - unf_sticky sets on dac_dunf in RUN or HALT; ctrl_unf_clr clears it.
//   clr and dunf in the same cycle -> sticky=1 (event kept).
// - dac_rst mid-operation: IDLE the next cycle; outputs 0; no partial delay resumes.
// CONFIGURATION
// - DAC_TX_SEQ_UNF_COUNT_EN defined:
//   - unf_count increments on each dac_dunf cycle in RUN/HALT and saturates at all-ones.
//   - ctrl_unf_clr zeroes it; clr and dunf in the same cycle -> 1.
// - DAC_TX_SEQ_UNF_COUNT_EN undefined: unf_count is tied to 0 and the counter logic is absent.
// STRUCTURE
// - Package dac_tx_seq_pkg: state encodings (SEQ_IDLE..SEQ_HALT) and the 3-bit state width constant.
// - Sub-module dac_tx_seq_delay_cnt: loadable down-counter with a zero flag (load, en, value, zero).
// - FSM, edge detect and underflow status stay in the top level.
// TESTING
// - Arm, chan_enable=4'b0101, ext_sync_en=0, start_delay=3, tx_ready=1
//   -> state DELAY for 4 cycles, then RUN; dac_valid=0101, tx_valid=1.
// - ext_sync_en=1 with ext_sync held high at arm -> stays ARMED; ext_sync low then high -> DELAY next cycle.
// - RUN, unf_halt=0, dac_dunf for 2 cycles -> dac_data_zero high 2 cycles (lagging by 1); state RUN; unf_sticky=1.
// - RUN, unf_halt=1, dac_dunf 1 cycle -> HALT: dac_valid=0, tx_valid=1, dac_data_zero=1;
//   ctrl_arm -> ARMED.
// - RUN with tx_ready dropped 5 cycles -> dac_valid=0 exactly those cycles; ctrl_arm+ctrl_stop same cycle -> IDLE.
// - With macro, UNF_CNT_WIDTH=4: 20 dunf cycles -> unf_count=15; clr and dunf same cycle -> unf_count=1.

Source files
------------

// File: rtl/dac_tx_seq_pkg.sv
// Purpose: shared state encodings for the DAC transmit start sequencer.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
//
// Contents: SEQ_STATE_W (width of the seq_state output) and the seq_state_e
// encodings SEQ_IDLE..SEQ_HALT, which are visible to software via seq_state.
package dac_tx_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ARMED = 3'd1,
    SEQ_DELAY = 3'd2,
    SEQ_RUN   = 3'd3,
    SEQ_HALT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/dac_tx_seq_delay_cnt.sv
// Purpose: loadable down-counter with a zero flag, used for the trigger-to-RUN delay.
// Latency: load/decrement take effect on the next clock; zero is decoded from the register.
// Backpressure: none; decrement stops at zero and holds there until reloaded.
//
// Ports: clk, rst (sync, active-high), load (takes value, wins over en),
//        en (decrement while nonzero), value (load value), zero (count == 0).
module dac_tx_seq_delay_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/dac_tx_start_sequencer.sv
// Purpose: sequences start/stop of the JESD DAC TX datapath (arm, optional ext sync, delay, run, halt).
// Latency: control pulses change state one dac_clk later; dac_valid is a same-cycle gate on tx_ready.
// Backpressure: tx_ready low stalls dac_valid in RUN and holds the delay at zero until the link is ready.
//
// Ports: dac_clk/dac_rst (sync, active-high); ctrl_* control from the regmap;
//        start_delay, chan_enable (latched on accepted arm); ext_sync, tx_ready, dac_dunf from the
//        datapath; dac_valid, dac_data_zero, tx_valid, seq_state, unf_sticky, unf_count out.
// Build option: DAC_TX_SEQ_UNF_COUNT_EN enables the saturating underflow counter on unf_count;
//               without it unf_count is tied to zero.
module dac_tx_start_sequencer
  import dac_tx_seq_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int START_DELAY_WIDTH = 16,
  parameter int UNF_CNT_WIDTH     = 16
) (
  input  logic                         dac_clk,
  input  logic                         dac_rst,
  input  logic                         ctrl_arm,
  input  logic                         ctrl_stop,
  input  logic                         ctrl_ext_sync_en,
  input  logic                         ctrl_unf_halt,
  input  logic                         ctrl_unf_clr,
  input  logic [START_DELAY_WIDTH-1:0] start_delay,
  input  logic [NUM_CHANNELS-1:0]      chan_enable,
  input  logic                         ext_sync,
  input  logic                         tx_ready,
  input  logic                         dac_dunf,
  output logic [NUM_CHANNELS-1:0]      dac_valid,
  output logic                         dac_data_zero,
  output logic                         tx_valid,
  output logic [SEQ_STATE_W-1:0]       seq_state,
  output logic                         unf_sticky,
  output logic [UNF_CNT_WIDTH-1:0]     unf_count
);

  seq_state_e              state_q;
  logic [NUM_CHANNELS-1:0] en_q;
  logic                    tx_valid_q;
  logic                    data_zero_q;
  logic                    ext_sync_q;
  logic                    unf_sticky_q;
  logic                    unf_sticky_d;

  logic sync_trig;
  logic dly_load;
  logic dly_zero;
  logic unf_evt;

  // With sync disabled ARMED falls straight through; otherwise only a fresh
  // 0->1 edge counts, so a level that was already high at arm is ignored.
  assign sync_trig = !ctrl_ext_sync_en || (ext_sync && !ext_sync_q);

  // Reload on every entry into DELAY so a stopped or reset delay never resumes.
  assign dly_load = (state_q == SEQ_ARMED) && sync_trig;

  dac_tx_seq_delay_cnt #(
    .WIDTH (START_DELAY_WIDTH)
  ) u_delay_cnt (
    .clk   (dac_clk),
    .rst   (dac_rst),
    .load  (dly_load),
    .en    (state_q == SEQ_DELAY),
    .value (start_delay),
    .zero  (dly_zero)
  );

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      ext_sync_q <= 1'b0;
    end else begin
      ext_sync_q <= ext_sync;
    end
  end

  // Sequencer FSM; tx_valid and dac_data_zero are registered alongside the state.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state_q     <= SEQ_IDLE;
      en_q        <= '0;
      tx_valid_q  <= 1'b0;
      data_zero_q <= 1'b0;
    end else if (ctrl_stop) begin
      state_q     <= SEQ_IDLE;
      tx_valid_q  <= 1'b0;
      data_zero_q <= 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (ctrl_arm && (chan_enable != '0)) begin
            state_q <= SEQ_ARMED;
            en_q    <= chan_enable;
          end
        end
        SEQ_ARMED: begin
          if (sync_trig) begin
            state_q <= SEQ_DELAY;
          end
        end
        SEQ_DELAY: begin
          if (dly_zero && tx_ready) begin
            state_q    <= SEQ_RUN;
            tx_valid_q <= 1'b1;
          end
        end
        SEQ_RUN: begin
          if (dac_dunf && ctrl_unf_halt) begin
            state_q     <= SEQ_HALT;
            data_zero_q <= 1'b1;
          end else begin
            // Zero-fill the cycle after each underflow cycle.
            data_zero_q <= dac_dunf;
          end
        end
        SEQ_HALT: begin
          // Re-arm reuses the enables latched by the original arm.
          if (ctrl_arm) begin
            state_q     <= SEQ_ARMED;
            tx_valid_q  <= 1'b0;
            data_zero_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= SEQ_IDLE;
          tx_valid_q  <= 1'b0;
          data_zero_q <= 1'b0;
        end
      endcase
    end
  end

  // Underflow only matters while the link is being fed.
  assign unf_evt = dac_dunf && ((state_q == SEQ_RUN) || (state_q == SEQ_HALT));

  // A new event in the clear cycle wins so it is never lost.
  assign unf_sticky_d = unf_evt || (unf_sticky_q && !ctrl_unf_clr);

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      unf_sticky_q <= 1'b0;
    end else begin
      unf_sticky_q <= unf_sticky_d;
    end
  end

`ifdef DAC_TX_SEQ_UNF_COUNT_EN
  logic [UNF_CNT_WIDTH-1:0] unf_cnt_q;
  logic [UNF_CNT_WIDTH-1:0] unf_cnt_d;

  always_comb begin
    unf_cnt_d = unf_cnt_q;
    if (ctrl_unf_clr) begin
      unf_cnt_d = {{(UNF_CNT_WIDTH-1){1'b0}}, unf_evt};
    end else if (unf_evt && !(&unf_cnt_q)) begin
      unf_cnt_d = unf_cnt_q + UNF_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      unf_cnt_q <= '0;
    end else begin
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign unf_count = unf_cnt_q;
`else
  assign unf_count = '0;
`endif

  assign dac_valid     = (state_q == SEQ_RUN) ? (en_q & {NUM_CHANNELS{tx_ready}}) : '0;
  assign dac_data_zero = data_zero_q;
  assign tx_valid      = tx_valid_q;
  assign seq_state     = state_q;
  assign unf_sticky    = unf_sticky_q;

endmodule

// File: tb/tb_dac_tx_start_sequencer.sv
// Purpose: self-checking bench for dac_tx_start_sequencer with a cycle model and expected-value queue.
// Latency: one expected record per clock, compared on the following falling edge.
// Backpressure: tx_ready is dropped and restored to exercise the dac_valid gate and DELAY hold.
module tb_dac_tx_start_sequencer;

  localparam int NCH = 4;
  localparam int SDW = 16;
  localparam int UCW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic           dac_clk = 1'b0;
  logic           dac_rst;
  logic           ctrl_arm;
  logic           ctrl_stop;
  logic           ctrl_ext_sync_en;
  logic           ctrl_unf_halt;
  logic           ctrl_unf_clr;
  logic [SDW-1:0] start_delay;
  logic [NCH-1:0] chan_enable;
  logic           ext_sync;
  logic           tx_ready;
  logic           dac_dunf;
  logic [NCH-1:0] dac_valid;
  logic           dac_data_zero;
  logic           tx_valid;
  logic [2:0]     seq_state;
  logic           unf_sticky;
  logic [UCW-1:0] unf_count;

  always #5 dac_clk = ~dac_clk;

  dac_tx_start_sequencer #(
    .NUM_CHANNELS      (NCH),
    .START_DELAY_WIDTH (SDW),
    .UNF_CNT_WIDTH     (UCW)
  ) dut (
    .dac_clk          (dac_clk),
    .dac_rst          (dac_rst),
    .ctrl_arm         (ctrl_arm),
    .ctrl_stop        (ctrl_stop),
    .ctrl_ext_sync_en (ctrl_ext_sync_en),
    .ctrl_unf_halt    (ctrl_unf_halt),
    .ctrl_unf_clr     (ctrl_unf_clr),
    .start_delay      (start_delay),
    .chan_enable      (chan_enable),
    .ext_sync         (ext_sync),
    .tx_ready         (tx_ready),
    .dac_dunf         (dac_dunf),
    .dac_valid        (dac_valid),
    .dac_data_zero    (dac_data_zero),
    .tx_valid         (tx_valid),
    .seq_state        (seq_state),
    .unf_sticky       (unf_sticky),
    .unf_count        (unf_count)
  );

  typedef struct packed {
    logic [2:0]     st;
    logic           txv;
    logic           zero;
    logic           sticky;
    logic [UCW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural model state.
  logic [2:0]     m_st      = S_IDLE;
  logic [NCH-1:0] m_en      = '0;
  logic [SDW-1:0] m_cnt     = '0;
  logic           m_sync_pv = 1'b0;
  logic           m_sticky  = 1'b0;
  logic [UCW-1:0] m_ucnt    = '0;

  int delay_seen  = 0;
  int dv_low_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs driven; predicts the
  // registered outputs after the next rising edge and compares them one
  // falling edge later.
  task automatic tick();
    exp_t           e;
    exp_t           g;
    logic [2:0]     ns;
    logic [NCH-1:0] nen;
    logic [SDW-1:0] ncnt;
    logic           evt;
    #1;
    check_eq("dac_valid", {28'd0, dac_valid},
             {28'd0, (m_st == S_RUN) ? (m_en & {NCH{tx_ready}}) : 4'h0});
    if ((m_st == S_RUN) && (dac_valid == 4'h0)) dv_low_seen++;

    ns   = m_st;
    nen  = m_en;
    ncnt = m_cnt;
    case (m_st)
      S_IDLE:  if (ctrl_arm && (chan_enable != '0)) begin ns = S_ARMED; nen = chan_enable; end
      S_ARMED: if (!ctrl_ext_sync_en || (ext_sync && !m_sync_pv)) begin ns = S_DELAY; ncnt = start_delay; end
      S_DELAY: begin
        if (m_cnt == '0) begin
          if (tx_ready) ns = S_RUN;
        end else begin
          ncnt = m_cnt - 16'd1;
        end
      end
      S_RUN:   if (dac_dunf && ctrl_unf_halt) ns = S_HALT;
      S_HALT:  if (ctrl_arm) ns = S_ARMED;
      default: ns = S_IDLE;
    endcase
    if (ctrl_stop) ns = S_IDLE;

    evt      = dac_dunf && ((m_st == S_RUN) || (m_st == S_HALT));
    e.st     = ns;
    e.txv    = (ns == S_RUN) || (ns == S_HALT);
    e.zero   = (ns == S_HALT) || ((ns == S_RUN) && (m_st == S_RUN) && dac_dunf);
    e.sticky = evt || (m_sticky && !ctrl_unf_clr);
`ifdef DAC_TX_SEQ_UNF_COUNT_EN
    if (ctrl_unf_clr)                  e.cnt = {3'b000, evt};
    else if (evt && (m_ucnt != 4'hF))  e.cnt = m_ucnt + 4'd1;
    else                               e.cnt = m_ucnt;
`else
    e.cnt = '0;
`endif
    if (dac_rst) begin
      e    = '0;
      ns   = S_IDLE;
      nen  = '0;
      ncnt = '0;
    end
    exp_q.push_back(e);
    m_sync_pv = dac_rst ? 1'b0 : ext_sync;

    @(negedge dac_clk);
    g = exp_q.pop_front();
    check_eq("seq_state",     {29'd0, seq_state},     {29'd0, g.st});
    check_eq("tx_valid",      {31'd0, tx_valid},      {31'd0, g.txv});
    check_eq("dac_data_zero", {31'd0, dac_data_zero}, {31'd0, g.zero});
    check_eq("unf_sticky",    {31'd0, unf_sticky},    {31'd0, g.sticky});
    check_eq("unf_count",     {28'd0, unf_count},     {28'd0, g.cnt});
    if (seq_state == S_DELAY) delay_seen++;

    m_st     = ns;
    m_en     = nen;
    m_cnt    = ncnt;
    m_sticky = g.sticky;
    m_ucnt   = g.cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dac_rst          = 1'b1;
    ctrl_arm         = 1'b0;
    ctrl_stop        = 1'b0;
    ctrl_ext_sync_en = 1'b0;
    ctrl_unf_halt    = 1'b0;
    ctrl_unf_clr     = 1'b0;
    start_delay      = 16'd3;
    chan_enable      = 4'b0101;
    ext_sync         = 1'b0;
    tx_ready         = 1'b1;
    dac_dunf         = 1'b0;
    repeat (2) @(negedge dac_clk);
    tick();
    dac_rst = 1'b0;
    check_eq("reset_state", {29'd0, seq_state}, 32'd0);
    check_eq("reset_dac_valid", {28'd0, dac_valid}, 32'd0);

    // Arm with no channels enabled is ignored.
    chan_enable = 4'b0000; ctrl_arm = 1'b1; tick(); ctrl_arm = 1'b0; tick();
    check_eq("arm_zero_en_ignored", {29'd0, seq_state}, 32'd0);

    // Basic start: delay 3 gives four DELAY cycles, enables latched at arm.
    chan_enable = 4'b0101; delay_seen = 0;
    ctrl_arm = 1'b1; tick(); ctrl_arm = 1'b0;
    chan_enable = 4'b1111;
    repeat (8) tick();
    check_eq("delay_cycles_sd3", delay_seen, 32'd4);
    check_eq("run_dac_valid", {28'd0, dac_valid}, 32'h5);
    check_eq("run_tx_valid", {31'd0, tx_valid}, 32'd1);

    // Arm while running is ignored.
    ctrl_arm = 1'b1; tick(); ctrl_arm = 1'b0; tick();

    // tx_ready low for exactly five cycles.
    dv_low_seen = 0; tx_ready = 1'b0; repeat (5) tick();
    tx_ready = 1'b1; repeat (3) tick();
    check_eq("txrdy_drop_cycles", dv_low_seen, 32'd5);

    // Zero-fill on underflow, stays in RUN.
    ctrl_unf_halt = 1'b0; dac_dunf = 1'b1; repeat (2) tick();
    dac_dunf = 1'b0; repeat (3) tick();
    check_eq("zero_fill_stays_run", {29'd0, seq_state}, 32'd3);
    check_eq("sticky_after_unf", {31'd0, unf_sticky}, 32'd1);

    ctrl_unf_clr = 1'b1; tick(); ctrl_unf_clr = 1'b0; tick();
    check_eq("sticky_cleared", {31'd0, unf_sticky}, 32'd0);
    ctrl_unf_clr = 1'b1; dac_dunf = 1'b1; tick(); ctrl_unf_clr = 1'b0; dac_dunf = 1'b0; tick();
    check_eq("sticky_clr_and_unf", {31'd0, unf_sticky}, 32'd1);

    // Counter saturation, then clear coinciding with an event.
    ctrl_unf_clr = 1'b1; tick(); ctrl_unf_clr = 1'b0;
    dac_dunf = 1'b1; repeat (20) tick(); dac_dunf = 1'b0; tick();
`ifdef DAC_TX_SEQ_UNF_COUNT_EN
    check_eq("unf_count_saturate", {28'd0, unf_count}, 32'd15);
`else
    check_eq("unf_count_tied", {28'd0, unf_count}, 32'd0);
`endif
    ctrl_unf_clr = 1'b1; dac_dunf = 1'b1; tick(); ctrl_unf_clr = 1'b0; dac_dunf = 1'b0;
`ifdef DAC_TX_SEQ_UNF_COUNT_EN
    check_eq("unf_count_clr_and_unf", {28'd0, unf_count}, 32'd1);
`else
    check_eq("unf_count_tied2", {28'd0, unf_count}, 32'd0);
`endif
    tick();

    // Halt on underflow.
    ctrl_unf_halt = 1'b1; dac_dunf = 1'b1; tick(); dac_dunf = 1'b0; repeat (3) tick();
    check_eq("halt_state", {29'd0, seq_state}, 32'd4);
    check_eq("halt_tx_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("halt_data_zero", {31'd0, dac_data_zero}, 32'd1);
    check_eq("halt_dac_valid", {28'd0, dac_valid}, 32'd0);

    // Re-arm from HALT reuses latched enables (0101, not the current 0011).
    chan_enable = 4'b0011; start_delay = 16'd0; delay_seen = 0;
    ctrl_arm = 1'b1; tick(); ctrl_arm = 1'b0;
    check_eq("halt_rearm_armed", {29'd0, seq_state}, 32'd1);
    repeat (4) tick();
    check_eq("delay_cycles_sd0", delay_seen, 32'd1);
    check_eq("rearm_dac_valid", {28'd0, dac_valid}, 32'h5);

    // Stop wins over arm.
    ctrl_arm = 1'b1; ctrl_stop = 1'b1; tick(); ctrl_arm = 1'b0; ctrl_stop = 1'b0;
    check_eq("stop_over_arm", {29'd0, seq_state}, 32'd0);
    tick();

    // External sync: level high at arm does not trigger; a fresh edge does.
    ctrl_ext_sync_en = 1'b1; ext_sync = 1'b1; chan_enable = 4'b1010;
    ctrl_arm = 1'b1; tick(); ctrl_arm = 1'b0;
    repeat (4) tick();
    check_eq("sync_level_no_trig", {29'd0, seq_state}, 32'd1);
    ext_sync = 1'b0; tick(); ext_sync = 1'b1; tick();
    check_eq("sync_edge_trig", {29'd0, seq_state}, 32'd2);

    // Count at zero with tx_ready low holds in DELAY.
    tx_ready = 1'b0; repeat (5) tick();
    check_eq("delay_hold_txrdy", {29'd0, seq_state}, 32'd2);
    tx_ready = 1'b1; tick();
    check_eq("delay_release_run", {29'd0, seq_state}, 32'd3);

    // Reset mid-delay, then a fresh arm runs the full delay again.
    ctrl_stop = 1'b1; tick(); ctrl_stop = 1'b0;
    ctrl_ext_sync_en = 1'b0; start_delay = 16'd3;
    ctrl_arm = 1'b1; tick(); ctrl_arm = 1'b0; repeat (2) tick();
    dac_rst = 1'b1; tick(); dac_rst = 1'b0;
    check_eq("rst_mid_state", {29'd0, seq_state}, 32'd0);
    check_eq("rst_mid_sticky", {31'd0, unf_sticky}, 32'd0);
    delay_seen = 0;
    ctrl_arm = 1'b1; tick(); ctrl_arm = 1'b0; repeat (8) tick();
    check_eq("delay_after_rst", delay_seen, 32'd4);
    check_eq("after_rst_dac_valid", {28'd0, dac_valid}, 32'hA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
